// File: rtl/md_sequencer_if.sv
// Bus between the E stage and the multiply/divide sequencer.
// The E stage (master) launches operations and MTHI/MTLO writes; the
// sequencer (slave) returns busy, the D-stage stall request and HI/LO.
interface md_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wdata, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wdata, md_use_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller for the E stage.
// The result is computed when the operation is launched and held in the
// pending registers; a counter then models the fixed unit latency, and HI/LO
// are committed when the busy window ends (a divide by zero leaves them alone).
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  md_sequencer_if.slave  md
);

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        launch;
  logic        commit;
  logic [7:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        pending_dz;

  logic [31:0] launch_hi;
  logic [31:0] launch_lo;
  logic        launch_dz;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] dividend_s;
  logic signed [31:0] divisor_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] divisor_u;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  // Compute the launch-time result for every op; a zero or overflowing divisor is replaced by 1 so the dividers never see an undefined case.
  always_comb begin
    launch_hi  = 32'd0;
    launch_lo  = 32'd0;
    div_zero   = (md.rt_val == 32'd0);
    div_ovf    = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
    launch_dz  = md.op[1] && div_zero;
    prod_s     = $signed({{32{md.rs_val[31]}}, md.rs_val}) * $signed({{32{md.rt_val[31]}}, md.rt_val});
    prod_u     = {32'd0, md.rs_val} * {32'd0, md.rt_val};
    divisor_u  = div_zero ? 32'd1 : md.rt_val;
    dividend_s = $signed(md.rs_val);
    divisor_s  = (div_zero || div_ovf) ? 32'sd1 : $signed(md.rt_val);
    quot_s     = dividend_s / divisor_s;
    rem_s      = dividend_s % divisor_s;
    quot_u     = md.rs_val / divisor_u;
    rem_u      = md.rs_val % divisor_u;
    case (md.op)
      2'b00: begin
        launch_hi = prod_s[63:32];
        launch_lo = prod_s[31:0];
      end
      2'b01: begin
        launch_hi = prod_u[63:32];
        launch_lo = prod_u[31:0];
      end
      2'b10: begin
        launch_hi = rem_s;
        launch_lo = quot_s;
      end
      default: begin
        launch_hi = rem_u;
        launch_lo = quot_u;
      end
    endcase
  end

  // State register for the IDLE/BUSY sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: a start in IDLE launches, the last busy cycle commits, and a start while busy is ignored.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (md.start) begin
          launch     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latency counter loaded with LAT-1 at launch so busy lasts exactly LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (launch) begin
      cnt <= md.op[1] ? DIV_LOAD : MULT_LOAD;
    end else if (state == BUSY && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Capture the result at launch so later operand changes have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_dz <= 1'b0;
    end else if (launch) begin
      pending_hi <= launch_hi;
      pending_lo <= launch_lo;
      pending_dz <= launch_dz;
    end
  end

  // HI/LO update: commit at the end of the busy window, otherwise MTHI/MTLO in IDLE when no launch competes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit) begin
      if (!pending_dz) begin
        hi_q <= pending_hi;
        lo_q <= pending_lo;
      end
    end else if (state == IDLE && !md.start) begin
      if (md.mthi) begin
        hi_q <= md.wdata;
      end
      if (md.mtlo) begin
        lo_q <= md.wdata;
      end
    end
  end

  assign md.busy     = (state == BUSY);
  assign md.stall_md = md.md_use_D & (md.start | md.busy);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus random operations
// checked against a 64-bit arithmetic reference model of HI/LO and busy timing.
module tb_md_sequencer;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_sequencer_if m ();

  md_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag any launch or MTHI/MTLO presented while the unit is busy.
  always @(posedge clk) begin
    if (rst_n && m.busy && (m.start || m.mthi || m.mtlo)) begin
      mismatched++;
      $error("[TB] FAIL protocol: start/mt while busy observed 1 expected 0");
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: HI/LO after an operation, from plain 64-bit arithmetic.
  task automatic modelOp(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op_i)
      2'b00: begin
        p = sa * sb;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      2'b01: begin
        pu = ua * ub;
        exp_hi = pu[63:32];
        exp_lo = pu[31:0];
      end
      2'b10: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          exp_hi = r[31:0];
          exp_lo = q[31:0];
        end
      end
      default: begin
        if (b != 32'd0) begin
          exp_hi = a % b;
          exp_lo = a / b;
        end
      end
    endcase
  endtask

  // Launch one operation and check busy/stall/HI/LO over the whole window.
  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b,
                               input logic use_d, input bit rand_use);
    int          lat;
    logic [31:0] old_hi, old_lo;
    logic        d;
    lat    = op_i[1] ? DIV_CYCLES : MULT_CYCLES;
    old_hi = exp_hi;
    old_lo = exp_lo;
    @(negedge clk);
    m.start    = 1'b1;
    m.op       = op_i;
    m.rs_val   = a;
    m.rt_val   = b;
    m.mthi     = 1'b0;
    m.mtlo     = 1'b0;
    m.md_use_D = use_d;
    #1;
    checkOutput("launch_busy", {31'd0, m.busy}, 32'd0);
    checkOutput("launch_stall", {31'd0, m.stall_md}, {31'd0, use_d});
    modelOp(op_i, a, b);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      d          = rand_use ? 1'($urandom_range(0, 1)) : use_d;
      m.start    = 1'b0;
      m.rs_val   = $urandom;
      m.rt_val   = $urandom;
      m.md_use_D = d;
      #1;
      checkOutput($sformatf("busy_c%0d", i + 1), {31'd0, m.busy}, 32'd1);
      checkOutput($sformatf("stall_c%0d", i + 1), {31'd0, m.stall_md}, {31'd0, d});
      checkOutput($sformatf("hold_hi_c%0d", i + 1), m.hi, old_hi);
      checkOutput($sformatf("hold_lo_c%0d", i + 1), m.lo, old_lo);
    end
    @(negedge clk);
    m.md_use_D = 1'b1;
    #1;
    checkOutput("done_busy", {31'd0, m.busy}, 32'd0);
    checkOutput("done_stall", {31'd0, m.stall_md}, 32'd0);
    checkOutput($sformatf("hi_op%0d", op_i), m.hi, exp_hi);
    checkOutput($sformatf("lo_op%0d", op_i), m.lo, exp_lo);
    m.md_use_D = 1'b0;
  endtask

  // MTHI/MTLO write in IDLE, checked the cycle after.
  task automatic applyMoveTo(input logic hi_en, input logic lo_en, input logic [31:0] data);
    @(negedge clk);
    m.mthi  = hi_en;
    m.mtlo  = lo_en;
    m.wdata = data;
    @(negedge clk);
    m.mthi  = 1'b0;
    m.mtlo  = 1'b0;
    m.wdata = $urandom;
    if (hi_en) exp_hi = data;
    if (lo_en) exp_lo = data;
    #1;
    checkOutput("mt_hi", m.hi, exp_hi);
    checkOutput("mt_lo", m.lo, exp_lo);
    checkOutput("mt_busy", {31'd0, m.busy}, 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          pick;
    compared   = 0;
    mismatched = 0;
    exp_hi     = 32'd0;
    exp_lo     = 32'd0;
    rst_n      = 1'b0;
    m.start    = 1'b0;
    m.op       = 2'b00;
    m.rs_val   = 32'd0;
    m.rt_val   = 32'd0;
    m.mthi     = 1'b0;
    m.mtlo     = 1'b0;
    m.wdata    = 32'd0;
    m.md_use_D = 1'b0;

    // Reset values, with stall_md following start & md_use_D
    @(negedge clk);
    m.start    = 1'b1;
    m.md_use_D = 1'b1;
    #1;
    checkOutput("rst_busy", {31'd0, m.busy}, 32'd0);
    checkOutput("rst_hi", m.hi, 32'd0);
    checkOutput("rst_lo", m.lo, 32'd0);
    checkOutput("rst_stall", {31'd0, m.stall_md}, 32'd1);
    @(negedge clk);
    m.start    = 1'b0;
    m.md_use_D = 1'b0;
    rst_n      = 1'b1;

    // Directed cases
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h0000_0004, 1'b0, 1'b1);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
    applyMoveTo(1'b1, 1'b0, 32'h1234_5678);
    applyMoveTo(1'b0, 1'b1, 32'h9ABC_DEF0);
    applyStimulus(2'b11, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyMoveTo(1'b1, 1'b1, 32'hA5A5_0F0F);
    applyStimulus(2'b10, 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b1);

    // Asynchronous reset in the third busy cycle of a MULTU
    @(negedge clk);
    m.start  = 1'b1;
    m.op     = 2'b01;
    m.rs_val = 32'hDEAD_BEEF;
    m.rt_val = 32'h0000_1234;
    @(negedge clk);
    m.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    checkOutput("async_rst_busy", {31'd0, m.busy}, 32'd0);
    checkOutput("async_rst_hi", m.hi, 32'd0);
    checkOutput("async_rst_lo", m.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b01, 32'd3, 32'd3, 1'b0, 1'b0);

    // Random operations and MT writes
    for (int n = 0; n < 24; n++) begin
      pick = $urandom_range(0, 4);
      if (pick == 0) begin
        applyMoveTo(1'($urandom_range(0, 1)), 1'b1, $urandom);
      end else begin
        rop = 2'($urandom_range(0, 3));
        ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        case ($urandom_range(0, 5))
          0:       rb = 32'd0;
          1:       rb = 32'hFFFF_FFFF;
          2:       rb = 32'($urandom_range(1, 17));
          default: rb = $urandom;
        endcase
        applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
